// File: rtl/multdiv_ctrl.sv
// Sequencer between the control unit and the shared mult/div units: one op at a time,
// start pulse, wait for the unit's end flag (with timeout), capture into HI/LO.
module multdiv_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic        err_timeout,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        mult_start,
    input  logic        mult_end,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_start,
    input  logic        div_end,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b
);

    typedef enum logic [2:0] {
        IDLE, MSTART, MWAIT, DSTART, DWAIT, DONE, ERR
    } state_t;

    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div0_exc    <= 1'b0;
            err_timeout <= 1'b0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        unit_a <= a;
                        unit_b <= b;
                        busy   <= 1'b1;
                        if (!op_sel) begin
                            mult_start <= 1'b1;
                            state      <= MSTART;
                        end else if (b != '0) begin
                            div_start <= 1'b1;
                            state     <= DSTART;
                        end else begin
                            div0_exc <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                MSTART: begin
                    mult_start <= 1'b0;
                    cnt        <= '0;
                    state      <= MWAIT;
                end
                DSTART: begin
                    div_start <= 1'b0;
                    cnt       <= '0;
                    state     <= DWAIT;
                end
                // End flags are only looked at here, so a stale level left over
                // from the previous op during the start cycle never completes an op.
                MWAIT: begin
                    if (mult_end) begin
                        hi_out <= mult_hi;
                        lo_out <= mult_lo;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (cnt >= TO_LAST) begin
                        cnt         <= TO_MAX;
                        err_timeout <= 1'b1;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DWAIT: begin
                    if (div_end) begin
                        hi_out <= div_r;
                        lo_out <= div_q;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (cnt >= TO_LAST) begin
                        cnt         <= TO_MAX;
                        err_timeout <= 1'b1;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    div0_exc    <= 1'b0;
                    err_timeout <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
